// File: rtl/sram_arb.sv
// Single-port async SRAM arbiter/sequencer: MEM has fixed priority over IF, registered strobes, WAIT_CYCLES wait states.
// Optional one-entry fetch buffer is compiled in when SRAM_ARB_IBUF_EN is defined.
module sram_arb #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IF_REQ,
    input  logic [31:0]       IF_ADDR,
    output logic [31:0]       IF_RDATA,
    output logic              IF_ACK,
    input  logic              MEM_REQ,
    input  logic              MEM_WE,
    input  logic [31:0]       MEM_ADDR,
    input  logic [31:0]       MEM_WDATA,
    input  logic [3:0]        MEM_BE,
    output logic [31:0]       MEM_RDATA,
    output logic              MEM_ACK,
    output logic              STALL_REQ,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [31:0]       SRAM_WDATA,
    output logic              SRAM_DATA_OE,
    input  logic [31:0]       SRAM_RDATA,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic [3:0]        SRAM_BE_N
);
    localparam int unsigned WCNT_W  = 4;
    localparam int unsigned WADDR_W = 30;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               gnt_mem_q, gnt_mem_d;
    logic               we_q, we_d;
    logic [3:0]         be_q, be_d;
    logic [WADDR_W-1:0] addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        if_rdata_q, if_rdata_d;
    logic [31:0]        mem_rdata_q, mem_rdata_d;
    logic               if_ack_q, if_ack_d;
    logic               mem_ack_q, mem_ack_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               doe_q, doe_d;
    logic [3:0]         be_n_q, be_n_d;
    logic               unused_bits;

`ifdef SRAM_ARB_IBUF_EN
    logic               ibuf_valid_q, ibuf_valid_d;
    logic [WADDR_W-1:0] ibuf_addr_q, ibuf_addr_d;
    logic [31:0]        ibuf_data_q, ibuf_data_d;
    logic               ibuf_hit;

    assign ibuf_hit = IF_REQ & ~MEM_REQ & ibuf_valid_q & (IF_ADDR[31:2] == ibuf_addr_q);
`endif

    // Next state, latched request fields, and the strobe values for the next cycle
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        gnt_mem_d   = gnt_mem_q;
        we_d        = we_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
`ifdef SRAM_ARB_IBUF_EN
        ibuf_valid_d = ibuf_valid_q;
        ibuf_addr_d  = ibuf_addr_q;
        ibuf_data_d  = ibuf_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (MEM_REQ) begin
                    state_d   = MEM_WE ? WR : RD;
                    gnt_mem_d = 1'b1;
                    we_d      = MEM_WE;
                    be_d      = MEM_BE;
                    addr_d    = MEM_ADDR[31:2];
                    wdata_d   = MEM_WDATA;
                    wcnt_d    = WCNT_W'(WAIT_CYCLES);
`ifdef SRAM_ARB_IBUF_EN
                    if (MEM_WE && (MEM_ADDR[31:2] == ibuf_addr_q))
                        ibuf_valid_d = 1'b0;
`endif
                end
`ifdef SRAM_ARB_IBUF_EN
                else if (ibuf_hit) begin
                    state_d    = DONE;
                    gnt_mem_d  = 1'b0;
                    we_d       = 1'b0;
                    if_rdata_d = ibuf_data_q;
                end
`endif
                else if (IF_REQ) begin
                    state_d   = RD;
                    gnt_mem_d = 1'b0;
                    we_d      = 1'b0;
                    be_d      = 4'b1111;
                    addr_d    = IF_ADDR[31:2];
                    wcnt_d    = WCNT_W'(WAIT_CYCLES);
                end
            end
            RD: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end else begin
                    state_d = DONE;
                    if (gnt_mem_q) begin
                        mem_rdata_d = SRAM_RDATA;
                    end else begin
                        if_rdata_d = SRAM_RDATA;
`ifdef SRAM_ARB_IBUF_EN
                        ibuf_valid_d = 1'b1;
                        ibuf_addr_d  = addr_q;
                        ibuf_data_d  = SRAM_RDATA;
`endif
                    end
                end
            end
            WR: begin
                if (wcnt_q != '0) wcnt_d = wcnt_q - WCNT_W'(1);
                else              state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ce_n_d = 1'b1;
        oe_n_d = 1'b1;
        we_n_d = 1'b1;
        be_n_d = 4'b1111;
        doe_d  = 1'b0;
        case (state_d)
            RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = 4'b0000;
            end
            WR: begin
                ce_n_d = 1'b0;
                we_n_d = 1'b0;
                be_n_d = ~be_d;
                doe_d  = 1'b1;
            end
            DONE: begin
                // Write hold cycle: WE_N already high, bus still driven
                if (we_d) begin
                    ce_n_d = 1'b0;
                    be_n_d = ~be_d;
                    doe_d  = 1'b1;
                end
            end
            default: ;
        endcase

        if_ack_d  = (state_d == DONE) && !gnt_mem_d;
        mem_ack_d = (state_d == DONE) &&  gnt_mem_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            gnt_mem_q   <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            be_n_q      <= 4'b1111;
            doe_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            gnt_mem_q   <= gnt_mem_d;
            we_q        <= we_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            be_n_q      <= be_n_d;
            doe_q       <= doe_d;
        end
    end

`ifdef SRAM_ARB_IBUF_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            ibuf_valid_q <= 1'b0;
            ibuf_addr_q  <= '0;
            ibuf_data_q  <= '0;
        end else begin
            ibuf_valid_q <= ibuf_valid_d;
            ibuf_addr_q  <= ibuf_addr_d;
            ibuf_data_q  <= ibuf_data_d;
        end
    end
`endif

    assign IF_RDATA     = if_rdata_q;
    assign IF_ACK       = if_ack_q;
    assign MEM_RDATA    = mem_rdata_q;
    assign MEM_ACK      = mem_ack_q;
    assign SRAM_ADDR    = addr_q[ADDR_W-1:0];
    assign SRAM_WDATA   = wdata_q;
    assign SRAM_DATA_OE = doe_q;
    assign SRAM_CE_N    = ce_n_q;
    assign SRAM_OE_N    = oe_n_q;
    assign SRAM_WE_N    = we_n_q;
    assign SRAM_BE_N    = be_n_q;

    // Stall while any requester is still waiting for its acknowledge
    assign STALL_REQ = (IF_REQ & ~if_ack_q) | (MEM_REQ & ~mem_ack_q);

    assign unused_bits = ^{IF_ADDR[1:0], MEM_ADDR[1:0], addr_q};

endmodule

// File: tb/tb_sram_arb.sv
// Scoreboard bench for sram_arb: WAIT_CYCLES=1 and WAIT_CYCLES=3 instances, behavioural async SRAM model.
module tb_sram_arb;
    localparam int P_STB = 0, P_HOLD = 1, P_ADDR = 2, P_WDATA = 3, P_STALL = 4;
    localparam int P_IFRD = 5, P_MEMRD = 6, P_ACKS = 7, P_STBB = 8, P_BMISC = 9;

    typedef struct { int unsigned c; logic [31:0] d; bit chk; } ack_t;
    typedef struct { string nm; int unsigned c; int sel; logic [63:0] v; } probe_t;

    logic clk = 1'b0, rst = 1'b1;
    logic if_req = 0, mem_req = 0, mem_we = 0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic [3:0] mem_be = '0;
    logic [31:0] if_rdata, mem_rdata, sram_wdata, sram_rdata;
    logic if_ack, mem_ack, stall, doe, ce_n, oe_n, we_n;
    logic [19:0] sram_addr;
    logic [3:0] be_n;

    logic b_if_req = 0, b_mem_req = 0, b_mem_we = 0;
    logic [31:0] b_if_addr = '0, b_mem_addr = '0, b_mem_wdata = '0;
    logic [3:0] b_mem_be = '0;
    logic [31:0] b_if_rdata, b_unused_mrd, b_unused_wd, b_sram_rdata;
    logic b_if_ack, b_mem_ack, b_stall, b_doe, b_ce_n, b_oe_n, b_we_n;
    logic [19:0] b_sram_addr;
    logic [3:0] b_be_n;

    logic [31:0] sram [0:255];
    int unsigned cyc = 0;
    int total = 0, bad = 0;
    bit done = 0;
    ack_t q_if[$], q_mem[$], q_b[$];
    probe_t q_chk[$];
    ack_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_arb #(.ADDR_W(20), .WAIT_CYCLES(1)) u_dut (
        .CLK(clk), .RST(rst), .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_RDATA(if_rdata), .IF_ACK(if_ack),
        .MEM_REQ(mem_req), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_BE(mem_be),
        .MEM_RDATA(mem_rdata), .MEM_ACK(mem_ack), .STALL_REQ(stall), .SRAM_ADDR(sram_addr),
        .SRAM_WDATA(sram_wdata), .SRAM_DATA_OE(doe), .SRAM_RDATA(sram_rdata), .SRAM_CE_N(ce_n),
        .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_BE_N(be_n));

    sram_arb #(.ADDR_W(20), .WAIT_CYCLES(3)) u_dut3 (
        .CLK(clk), .RST(rst), .IF_REQ(b_if_req), .IF_ADDR(b_if_addr), .IF_RDATA(b_if_rdata), .IF_ACK(b_if_ack),
        .MEM_REQ(b_mem_req), .MEM_WE(b_mem_we), .MEM_ADDR(b_mem_addr), .MEM_WDATA(b_mem_wdata), .MEM_BE(b_mem_be),
        .MEM_RDATA(b_unused_mrd), .MEM_ACK(b_mem_ack), .STALL_REQ(b_stall), .SRAM_ADDR(b_sram_addr),
        .SRAM_WDATA(b_unused_wd), .SRAM_DATA_OE(b_doe), .SRAM_RDATA(b_sram_rdata), .SRAM_CE_N(b_ce_n),
        .SRAM_OE_N(b_oe_n), .SRAM_WE_N(b_we_n), .SRAM_BE_N(b_be_n));

    // Async SRAM model; contents are reloaded whenever reset is high
    assign sram_rdata   = (!ce_n && !oe_n) ? sram[sram_addr[7:0]] : 32'hBAD0_BAD0;
    assign b_sram_rdata = (!b_ce_n && !b_oe_n) ? (32'hCAFE_0000 | 32'(b_sram_addr)) : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) sram[i] <= '0;
            sram[1]  <= 32'h1234_5678;
            sram[2]  <= 32'h5A5A_C3C3;
            sram[64] <= 32'hA5A5_0100;
        end else if (!ce_n && !we_n) begin
            for (int i = 0; i < 4; i++)
                if (!be_n[i]) sram[sram_addr[7:0]][8*i +: 8] <= sram_wdata[8*i +: 8];
        end
    end

    function automatic logic [63:0] obs(input int sel);
        case (sel)
            P_STB:   obs = 64'({ce_n, oe_n, we_n, doe, be_n});
            P_HOLD:  obs = 64'({ce_n, we_n, doe});
            P_ADDR:  obs = 64'(sram_addr);
            P_WDATA: obs = 64'(sram_wdata);
            P_STALL: obs = 64'(stall);
            P_IFRD:  obs = 64'(if_rdata);
            P_MEMRD: obs = 64'(mem_rdata);
            P_ACKS:  obs = 64'({if_ack, mem_ack});
            P_STBB:  obs = 64'({b_ce_n, b_oe_n, b_we_n, b_doe, b_be_n});
            P_BMISC: obs = 64'({b_mem_ack, b_stall});
            default: obs = '1;
        endcase
    endfunction

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: the only process that compares and counts
    always @(negedge clk) begin
        if (if_ack) begin
            if (q_if.size() == 0) cmp("if_ack_unexpected", 1, 0);
            else begin
                e = q_if.pop_front();
                cmp("if_ack_cycle", 64'(cyc), 64'(e.c));
                if (e.chk) cmp("if_rdata", 64'(if_rdata), 64'(e.d));
            end
        end
        if (mem_ack) begin
            if (q_mem.size() == 0) cmp("mem_ack_unexpected", 1, 0);
            else begin
                e = q_mem.pop_front();
                cmp("mem_ack_cycle", 64'(cyc), 64'(e.c));
                if (e.chk) cmp("mem_rdata", 64'(mem_rdata), 64'(e.d));
            end
        end
        if (b_if_ack) begin
            if (q_b.size() == 0) cmp("b_if_ack_unexpected", 1, 0);
            else begin
                e = q_b.pop_front();
                cmp("b_if_ack_cycle", 64'(cyc), 64'(e.c));
                if (e.chk) cmp("b_if_rdata", 64'(b_if_rdata), 64'(e.d));
            end
        end
        for (int i = 0; i < q_chk.size(); ) begin
            if (q_chk[i].c == cyc) begin
                cmp(q_chk[i].nm, obs(q_chk[i].sel), q_chk[i].v);
                q_chk.delete(i);
            end else i++;
        end
        if (done) begin
            while (q_if.size() > 0)  begin e = q_if.pop_front();  cmp("if_ack_missing", 0, 64'(e.c)); end
            while (q_mem.size() > 0) begin e = q_mem.pop_front(); cmp("mem_ack_missing", 0, 64'(e.c)); end
            while (q_b.size() > 0)   begin e = q_b.pop_front();   cmp("b_ack_missing", 0, 64'(e.c)); end
            while (q_chk.size() > 0) begin cmp("probe_unvisited", 0, 64'(q_chk[0].c)); q_chk.delete(0); end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
        if (cyc > 3000) begin
            $display("FAIL watchdog at cycle %0d", cyc);
            $fatal(1);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic probe(input string nm, input int unsigned c, input int sel, input logic [63:0] v);
        probe_t p;
        p.nm = nm; p.c = c; p.sel = sel; p.v = v;
        q_chk.push_back(p);
    endtask

    task automatic push_ack(input int which, input int unsigned c, input logic [31:0] d, input bit chk);
        ack_t a;
        a.c = c; a.d = d; a.chk = chk;
        if (which == 0) q_if.push_back(a);
        else if (which == 1) q_mem.push_back(a);
        else q_b.push_back(a);
    endtask

    // Read strobe window for an access accepted at cycle t
    task automatic rd_window(input int sel, input int unsigned t, input int unsigned wc);
        probe("stb_pre", t, sel, 64'hEF);
        for (int unsigned k = 1; k <= wc + 1; k++) probe("stb_rd", t + k, sel, 64'h20);
        probe("stb_done", t + wc + 2, sel, 64'hEF);
        probe("stb_post", t + wc + 3, sel, 64'hEF);
    endtask

    task automatic wait_if(input int unsigned maxc);
        for (int unsigned k = 0; k < maxc; k++) begin if (if_ack) break; tick(); end
        if_req = 0;
    endtask

    task automatic wait_mem(input int unsigned maxc);
        for (int unsigned k = 0; k < maxc; k++) begin if (mem_ack) break; tick(); end
        mem_req = 0;
    endtask

    task automatic if_read(input logic [31:0] a, input int unsigned lat, input logic [31:0] d);
        int unsigned t;
        tick(); t = cyc;
        push_ack(0, t + lat, d, 1);
        if (lat == 1) begin
            probe("stb_hit0", t, P_STB, 64'hEF);
            probe("stb_hit1", t + 1, P_STB, 64'hEF);
            probe("stb_hit2", t + 2, P_STB, 64'hEF);
        end else rd_window(P_STB, t, 1);
        if_addr = a; if_req = 1;
        wait_if(12);
    endtask

    task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic [7:0] stb);
        int unsigned t;
        tick(); t = cyc;
        push_ack(1, t + 3, '0, 0);
        probe("wr_pre", t, P_STB, 64'hEF);
        probe("wr_stb1", t + 1, P_STB, 64'(stb));
        probe("wr_stb2", t + 2, P_STB, 64'(stb));
        probe("wr_hold", t + 3, P_HOLD, 64'b011);
        probe("wr_post", t + 4, P_STB, 64'hEF);
        for (int unsigned k = 1; k <= 3; k++) begin
            probe("wr_addr", t + k, P_ADDR, 64'(a[21:2]));
            probe("wr_wdata", t + k, P_WDATA, 64'(d));
        end
        probe("wr_stall0", t, P_STALL, 64'd1);
        probe("wr_stall2", t + 2, P_STALL, 64'd1);
        probe("wr_noack", t + 2, P_ACKS, 64'd0);
        mem_we = 1; mem_addr = a; mem_wdata = d; mem_be = be; mem_req = 1;
        wait_mem(12);
    endtask

    initial begin
        int unsigned t;
        repeat (3) tick();
        t = cyc;
        probe("rst_stb", t, P_STB, 64'hEF);
        probe("rst_acks", t, P_ACKS, 64'd0);
        probe("rst_addr", t, P_ADDR, 64'd0);
        probe("rst_wdata", t, P_WDATA, 64'd0);
        probe("rst_stall", t, P_STALL, 64'd0);
        probe("rst_stbb", t, P_STBB, 64'hEF);
        tick(); rst = 0;

        mem_write(32'h0000_0010, 32'hDEAD_BEEF, 4'b0011, 8'h5C);

        if_read(32'h0000_0004, 3, 32'h1234_5678);
        probe("if_rdata_held", cyc + 3, P_IFRD, 64'h1234_5678);
        repeat (4) tick();

        tick(); t = cyc;
        push_ack(1, t + 3, 32'h0000_BEEF, 1);
        rd_window(P_STB, t, 1);
        probe("rd_addr", t + 1, P_ADDR, 64'h4);
        mem_we = 0; mem_addr = 32'h10; mem_req = 1;
        wait_mem(12);

        // Collision: MEM wins, IF follows after MEM drops its request
        tick(); t = cyc;
        push_ack(1, t + 3, 32'h0000_BEEF, 1);
        push_ack(0, t + 7, 32'h5A5A_C3C3, 1);
        rd_window(P_STB, t, 1);
        rd_window(P_STB, t + 4, 1);
        probe("col_addr_mem", t + 1, P_ADDR, 64'h4);
        probe("col_addr_if", t + 5, P_ADDR, 64'h2);
        for (int unsigned k = 0; k <= 7; k++) probe("col_stall", t + k, P_STALL, (k < 7) ? 64'd1 : 64'd0);
        mem_we = 0; mem_addr = 32'h10; mem_req = 1;
        if_addr = 32'h8; if_req = 1;
        for (int k = 0; k < 20; k++) begin
            if (mem_ack) mem_req = 0;
            if (if_ack) break;
            tick();
        end
        if_req = 0; mem_req = 0;

        // Reset during the first write cycle drops the access
        tick(); t = cyc;
        probe("rw_stb1", t + 1, P_STB, 64'h50);
        probe("rw_stb", t + 2, P_STB, 64'hEF);
        probe("rw_acks2", t + 2, P_ACKS, 64'd0);
        probe("rw_addr", t + 2, P_ADDR, 64'd0);
        probe("rw_wdata", t + 2, P_WDATA, 64'd0);
        probe("rw_ifrd", t + 2, P_IFRD, 64'd0);
        probe("rw_memrd", t + 2, P_MEMRD, 64'd0);
        probe("rw_acks3", t + 3, P_ACKS, 64'd0);
        probe("rw_acks4", t + 4, P_ACKS, 64'd0);
        probe("rw_stb3", t + 3, P_STB, 64'hEF);
        mem_we = 1; mem_addr = 32'h24; mem_wdata = 32'h0102_0304; mem_be = 4'b1111; mem_req = 1;
        tick(); rst = 1; mem_req = 0;
        tick(); rst = 0;
        tick();
        if_read(32'h0000_0004, 3, 32'h1234_5678);

        // WAIT_CYCLES=3 instance
        tick(); t = cyc;
        push_ack(2, t + 5, 32'hCAFE_0008, 1);
        rd_window(P_STBB, t, 3);
        for (int unsigned k = 0; k <= 5; k++) probe("b_stall", t + k, P_BMISC, (k < 5) ? 64'd1 : 64'd0);
        b_if_addr = 32'h20; b_if_req = 1;
        for (int k = 0; k < 20; k++) begin if (b_if_ack) break; tick(); end
        b_if_req = 0;

        // Repeated fetch: buffer hit when compiled in, full access otherwise
        if_read(32'h0000_0100, 3, 32'hA5A5_0100);
`ifdef SRAM_ARB_IBUF_EN
        if_read(32'h0000_0100, 1, 32'hA5A5_0100);
`else
        if_read(32'h0000_0100, 3, 32'hA5A5_0100);
`endif
        mem_write(32'h0000_0100, 32'h1111_2222, 4'b1111, 8'h50);
        if_read(32'h0000_0100, 3, 32'h1111_2222);

        repeat (4) tick();
        done = 1;
        repeat (10) tick();
        $display("FAIL monitor did not finish");
        $fatal(1);
    end
endmodule

// File: doc/sram_arb.md
# sram_arb

Single-port SRAM arbiter and access sequencer that shares one external asynchronous SRAM between instruction fetch (IF) and the data-memory stage (MEM). It latches one request at a time and drives registered SRAM strobes with a configurable number of wait states. It returns read data with a one-cycle acknowledge and raises a stall request toward the pipeline controller while any requester is waiting.

## Interface
- ADDR_W, 20, SRAM word-address width.
- WAIT_CYCLES, 1, extra cycles the strobes are held beyond the first access cycle (0..15).
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- IF_REQ  in  1  fetch read request, level, held until IF_ACK.
- IF_ADDR  in  32  fetch byte address, stable while IF_REQ=1.
- IF_RDATA  out  32  fetched word, valid while IF_ACK=1, held until the next IF_ACK.
- IF_ACK  out  1  one-cycle completion pulse.
- MEM_REQ  in  1  data request, level, held until MEM_ACK.
- MEM_WE  in  1  1=write, 0=read.
- MEM_ADDR  in  32  data byte address.
- MEM_WDATA  in  32  write data.
- MEM_BE  in  4  active-high byte enables for writes.
- MEM_RDATA  out  32  load word, valid while MEM_ACK=1, held until the next MEM_ACK.
- MEM_ACK  out  1  one-cycle completion pulse.
- STALL_REQ  out  1  pipeline stall request.
- SRAM_ADDR  out  ADDR_W  word address, taken from the byte address bits [ADDR_W+1:2].
- SRAM_WDATA  out  32  write data.
- SRAM_DATA_OE  out  1  1 drives the SRAM data bus. The tristate buffer sits outside this block.
- SRAM_RDATA  in  32  SRAM data bus input.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  out  1 each  active-low strobes.
- SRAM_BE_N  out  4  active-low byte enables.

## Operation
- FSM states: IDLE, RD, WR, DONE. A down-counter `wcnt` (4 bits) holds the remaining wait cycles.
- IDLE accepts a request only if one is pending. MEM_REQ has fixed priority over IF_REQ.
- On accept, the block latches the address, write data, BE, WE and grant source (`gnt_mem`). It loads `wcnt` with WAIT_CYCLES and moves to RD or WR.
- RD strobes: CE_N=0, OE_N=0, WE_N=1, BE_N=4'b0000, DATA_OE=0.
- WR strobes: CE_N=0, OE_N=1, WE_N=0, BE_N=~BE, DATA_OE=1.
- In RD or WR, if `wcnt`≠0 the counter decrements. If `wcnt`=0 the FSM moves to DONE. RD also samples SRAM_RDATA into the granted requester's RDATA register on that edge.
- DONE pulses the granted ACK for one cycle. For a write, DONE is the hold cycle: CE_N=0, WE_N=1, DATA_OE=1, with address and data unchanged. For a read, all strobes are inactive. DONE always goes to IDLE.
- STALL_REQ = (IF_REQ & ~IF_ACK) | (MEM_REQ & ~MEM_ACK), combinational.
- Requester rule: in the cycle after its ACK, a requester either deasserts REQ or presents its next request. A REQ still high in IDLE is treated as a new request.
- Reset, including mid-access: FSM goes to IDLE. CE_N, OE_N and WE_N go to 1, BE_N to 4'b1111, DATA_OE to 0. Both ACKs go to 0, IF_RDATA and MEM_RDATA to 0, SRAM_ADDR and SRAM_WDATA to 0. Any in-flight access is dropped without an ACK.

## Timing
- All SRAM outputs and ACKs are registered. STALL_REQ is the only combinational output.
- Request accepted in IDLE at cycle t:
  - strobes are active for cycles t+1 .. t+1+WAIT_CYCLES;
  - ACK is high at t+2+WAIT_CYCLES (t+3 at default);
  - earliest next accept is t+3+WAIT_CYCLES.
- Address and write data are stable for the whole strobe window. For writes they stay stable through the WE_N rising edge plus one cycle of hold.
- If MEM_REQ and IF_REQ are both high in IDLE, MEM is served first. IF is accepted in the IDLE that follows MEM's DONE, provided MEM has deasserted.

## Configuration
- SRAM_ARB_IBUF_EN: enables a one-entry fetch buffer holding `ibuf_valid`, `ibuf_addr[31:2]` and `ibuf_data`.
  - Fill: every completed IF read.
  - Hit condition, checked in IDLE: IF_REQ=1, MEM_REQ=0, ibuf_valid=1, IF_ADDR[31:2]=ibuf_addr.
  - On a hit the FSM goes directly to DONE with no SRAM strobes. IF_ACK is high at t+1 and IF_RDATA=ibuf_data.
  - Invalidate: an accepted MEM write whose MEM_ADDR[31:2] matches ibuf_addr clears ibuf_valid. RST also clears ibuf_valid.
- Without the macro, every IF request accesses SRAM and the buffer logic is absent.

## Test plan
- MEM write: MEM_WE=1, MEM_ADDR=0x0000_0010, MEM_WDATA=0xDEADBEEF, MEM_BE=4'b0011, WAIT_CYCLES=1. Required: SRAM_ADDR=0x00004; WE_N=0 for 2 cycles, then one hold cycle with WE_N=1, CE_N=0, DATA_OE=1; BE_N=4'b1100; MEM_ACK at t+3.
- IF read: IF_ADDR=0x0000_0004, SRAM model returns 0x12345678. Required: OE_N=0 for 2 cycles; IF_ACK at t+3 with IF_RDATA=0x12345678, held after IF_REQ drops.
- Collision: IF_REQ and MEM_REQ (read) raised in the same cycle. Required: MEM_ACK at t+3; IF_ACK at t+7 (WAIT_CYCLES=1, MEM deasserts after its ACK); STALL_REQ=1 until the IF_ACK cycle.
- Reset mid-write: RST asserted in the first WR cycle. Required: the next cycle shows WE_N=1, CE_N=1, DATA_OE=0, BE_N=4'b1111; no ACK; FSM in IDLE.
- WAIT_CYCLES=3 read: required ACK at t+5 and exactly 4 strobe cycles.
- With SRAM_ARB_IBUF_EN, IF fetch of 0x100 (miss), then repeated 0x100. Required: the repeat gets IF_ACK at t+1 with no CE_N activity. After a MEM write to 0x100, the next IF fetch of 0x100 accesses SRAM again.
